ascon_perm_ctrl: RTL and testbench

//   Round sequencer for the Ascon-128 permutation. On a start pulse it captures the 320-bit state x0..x4 and the round count.
//   It then iterates one ascon_round datapath per cycle, applying the correct round constants.
//   It presents the permuted state with a done pulse.

---
 rtl/ascon_perm_ctrl_pkg.sv | 37 +++
 rtl/ascon_perm_ctrl_if.sv | 35 +++
 rtl/ascon_perm_ctrl_round.sv | 54 +++++
 rtl/ascon_perm_ctrl.sv | 129 ++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_perm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ascon_perm_ctrl_pkg
//   Shared definitions for the Ascon permutation sequencer:
//     MAX_ROUNDS    longest permutation (p^a), round indices 0..MAX_ROUNDS-1
//     CNT_W         width of the round counter and of the requested count
//     ascon_state_t 320-bit state, x0 in the most significant word
//     ctrl_state_e  sequencer FSM states
//     rc()          round constant for a round index
// ---------------------------------------------------------------------------
package ascon_perm_ctrl_pkg;

  localparam int MAX_ROUNDS = 12;
  localparam int CNT_W      = 4;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } ctrl_state_e;

  // Constant for round index r: high nibble counts down from F while the
  // low nibble counts up, so index 0 gives F0 and index 11 gives 4B.
  function automatic logic [7:0] rc(input logic [CNT_W-1:0] r);
    logic [3:0] hi;
    hi = 4'hF - r[3:0];
    return {hi, r[3:0]};
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// ---------------------------------------------------------------------------
// ascon_perm_ctrl_if
//   Request/result bundle between the CSR block and the permutation sequencer.
//   master : CSR side, drives iStart/iRounds/iX0..iX4, reads oX0..oX4 + flags
//   slave  : sequencer side
//   iStart   start request (only honoured while the sequencer is idle)
//   iRounds  requested round count (values above MAX_ROUNDS run MAX_ROUNDS)
//   iX0..iX4 input state words, captured with an accepted start
//   oX0..oX4 working / final state words
//   oBusy    permutation in progress
//   oDone    one-cycle pulse when oX0..oX4 hold the final state
//   oValid   level, result held; cleared by the next accepted start
// ---------------------------------------------------------------------------
interface ascon_perm_ctrl_if;
  import ascon_perm_ctrl_pkg::*;

  logic             iStart;
  logic [CNT_W-1:0] iRounds;
  logic [63:0]      iX0, iX1, iX2, iX3, iX4;
  logic [63:0]      oX0, oX1, oX2, oX3, oX4;
  logic             oBusy;
  logic             oDone;
  logic             oValid;

  modport master (
    output iStart, iRounds, iX0, iX1, iX2, iX3, iX4,
    input  oX0, oX1, oX2, oX3, oX4, oBusy, oDone, oValid
  );

  modport slave (
    input  iStart, iRounds, iX0, iX1, iX2, iX3, iX4,
    output oX0, oX1, oX2, oX3, oX4, oBusy, oDone, oValid
  );

endinterface

// File: rtl/ascon_perm_ctrl_round.sv
// ---------------------------------------------------------------------------
// ascon_perm_ctrl_round
//   One Ascon round, purely combinational:
//   constant addition into x2[7:0], 5-bit S-box bitsliced over the 64
//   columns, then the per-word linear diffusion layer.
//   state_i  state entering the round
//   round_i  round index selecting the constant
//   state_o  state after the round
// ---------------------------------------------------------------------------
module ascon_perm_ctrl_round
  import ascon_perm_ctrl_pkg::*;
(
  input  ascon_state_t     state_i,
  input  logic [CNT_W-1:0] round_i,
  output ascon_state_t     state_o
);

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] s0, s1, s2, s3, s4;

  // Constant addition folded into the S-box input mixing.
  assign a0 = state_i.x0 ^ state_i.x4;
  assign a1 = state_i.x1;
  assign a2 = state_i.x2 ^ {56'd0, rc(round_i)} ^ state_i.x1;
  assign a3 = state_i.x3;
  assign a4 = state_i.x4 ^ state_i.x3;

  // Chi-like core: each word absorbs (~next & next-next).
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  // Output mixing of the S-box.
  assign s0 = b0 ^ b4;
  assign s1 = b1 ^ b0;
  assign s2 = ~b2;
  assign s3 = b3 ^ b2;
  assign s4 = b4;

  // Linear diffusion layer.
  assign state_o.x0 = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
  assign state_o.x1 = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
  assign state_o.x2 = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
  assign state_o.x3 = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
  assign state_o.x4 = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);

endmodule

// File: rtl/ascon_perm_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_perm_ctrl
//   Round sequencer for the Ascon permutation. An accepted start captures the
//   state and the (clamped) round count a, then rounds MAX_ROUNDS-a ..
//   MAX_ROUNDS-1 are applied, one per clock by default. The result is held
//   on oX0..oX4 with a one-cycle oDone pulse and a sticky oValid.
//   iClk    rising-edge clock
//   iReset  synchronous active-high reset (aborts a running permutation)
//   bus     ascon_perm_ctrl_if.slave: start/rounds/state in, state/flags out
// Build option:
//   ASCON_TWO_ROUNDS_EN  two chained rounds per clock; an odd remaining round
//                        takes only the first stage on the final edge.
// ---------------------------------------------------------------------------
module ascon_perm_ctrl
  import ascon_perm_ctrl_pkg::*;
(
  input  logic             iClk,
  input  logic             iReset,
  ascon_perm_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_ROUNDS - 1);

  ctrl_state_e      state_q;
  ascon_state_t     x_q;
  logic [CNT_W-1:0] r_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;

  ascon_state_t     x_in;
  logic [CNT_W-1:0] a_norm;
  logic [CNT_W-1:0] r0;
  ascon_state_t     rnd0;
  ascon_state_t     step_d;
  logic [CNT_W-1:0] r_d;
  logic             fin;

  assign x_in   = {bus.iX0, bus.iX1, bus.iX2, bus.iX3, bus.iX4};
  assign a_norm = (bus.iRounds > MAX_CNT) ? MAX_CNT : bus.iRounds;
  // Shorter permutations use the tail of the constant schedule.
  assign r0     = MAX_CNT - a_norm;

  ascon_perm_ctrl_round u_round0 (
    .state_i (x_q),
    .round_i (r_q),
    .state_o (rnd0)
  );

`ifdef ASCON_TWO_ROUNDS_EN
  ascon_state_t     rnd1;
  logic [CNT_W-1:0] r_plus1;

  assign r_plus1 = r_q + CNT_W'(1);

  ascon_perm_ctrl_round u_round1 (
    .state_i (rnd0),
    .round_i (r_plus1),
    .state_o (rnd1)
  );

  // With only the last index left, the second stage would overrun the
  // schedule, so the first stage result is taken instead.
  assign step_d = (r_q == LAST_IDX) ? rnd0 : rnd1;
  assign r_d    = r_q + CNT_W'(2);
  assign fin    = (r_q >= LAST_IDX - CNT_W'(1));
`else
  assign step_d = rnd0;
  assign r_d    = r_q + CNT_W'(1);
  assign fin    = (r_q == LAST_IDX);
`endif

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iStart) begin
            x_q <= x_in;
            if (a_norm == '0) begin
              // Zero rounds: the captured state is already the result.
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              r_q     <= r0;
              valid_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          x_q <= step_d;
          r_q <= r_d;
          if (fin) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // One dead cycle so a held-high start cannot retrigger immediately.
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.oX0    = x_q.x0;
  assign bus.oX1    = x_q.x1;
  assign bus.oX2    = x_q.x2;
  assign bus.oX3    = x_q.x3;
  assign bus.oX4    = x_q.x4;
  assign bus.oBusy  = busy_q;
  assign bus.oDone  = done_q;
  assign bus.oValid = valid_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascon_perm_ctrl
//   Directed vector table for single jobs, plus hand-written sequences for
//   reset, mid-run reset and a continuously held start request. Expected
//   states come from a table-lookup S-box reference model.
// ---------------------------------------------------------------------------
module tb_ascon_perm_ctrl;

  typedef logic [4:0][63:0] st_t;   // index 0 = x0

  typedef struct {
    string      name;
    logic [3:0] rounds;
    st_t        x_in;
    st_t        exp_out;
    int         exp_edges;          // edges from accept until oDone visible, inclusive
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ascon_perm_ctrl_if bus ();

  ascon_perm_ctrl dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox(input logic [4:0] i);
    case (i)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic st_t model_round(input st_t s, input int r);
    st_t        t;
    logic [4:0] idx, o;
    logic [7:0] c;
    c = 8'(((15 - r) << 4) | r);
    s[2][7:0] = s[2][7:0] ^ c;
    for (int b = 0; b < 64; b++) begin
      idx = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o   = sbox(idx);
      t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
    end
    s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
    s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
    s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
    s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
    s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    return s;
  endfunction

  function automatic int clamp12(input int a);
    return (a > 12) ? 12 : a;
  endfunction

  function automatic st_t model_perm(input st_t s, input int a);
    for (int r = 12 - clamp12(a); r < 12; r++) s = model_round(s, r);
    return s;
  endfunction

  function automatic int exp_edges(input int a);
    int ac;
    ac = clamp12(a);
    if (ac == 0) return 1;
`ifdef ASCON_TWO_ROUNDS_EN
    return (ac + 1) / 2 + 1;
`else
    return ac + 1;
`endif
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_int(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_st(input string name, input st_t act, input st_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic st_t dut_out();
    st_t s;
    s[0] = bus.oX0; s[1] = bus.oX1; s[2] = bus.oX2; s[3] = bus.oX3; s[4] = bus.oX4;
    return s;
  endfunction

  task automatic drive(input logic start, input logic [3:0] rounds, input st_t x);
    bus.iStart = start; bus.iRounds = rounds;
    bus.iX0 = x[0]; bus.iX1 = x[1]; bus.iX2 = x[2]; bus.iX3 = x[3]; bus.iX4 = x[4];
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_vec(input vec_t v);
    int  edges, busy_bad;
    st_t got;
    bit  valid_after_acc;
    drive(1'b1, v.rounds, v.x_in);
    @(negedge clk);
    drive(1'b0, 4'(v.rounds + 3), rand_st());   // junk inputs must be ignored
    edges = 1;
    busy_bad = 0;
    valid_after_acc = bus.oValid;
    while (!bus.oDone && edges < 40) begin
      if (bus.oBusy !== 1'b1) busy_bad++;
      @(negedge clk);
      edges++;
    end
    got = dut_out();
    check_st({v.name, " result"}, got, v.exp_out);
    check_int({v.name, " latency"}, edges, v.exp_edges);
    check_int({v.name, " busy_low_in_run"}, busy_bad, 0);
    check_int({v.name, " busy_at_done"}, bus.oBusy, 0);
    check_int({v.name, " valid_after_accept"}, valid_after_acc, (clamp12(v.rounds) == 0) ? 1 : 0);
    @(negedge clk);
    check_int({v.name, " done_pulse_width"}, bus.oDone, 0);
    check_int({v.name, " valid_held"}, bus.oValid, 1);
    check_st({v.name, " result_stable"}, dut_out(), v.exp_out);
    $display("[TB] job %s rounds=%0d edges=%0d", v.name, v.rounds, edges);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[7];
  st_t  xs[64];

  initial begin : main
    st_t rs, rs2;
    int  L, n_done, done1, done2;
    st_t res1, res2;

    rs  = rand_st();
    rs2 = rand_st();
    vecs[0] = '{"p12_zero",  4'd12, '0,   '0, 0};
    vecs[1] = '{"p6_rand",   4'd6,  rs,   '0, 0};
    vecs[2] = '{"p0_pass",   4'd0,  rs,   '0, 0};
    vecs[3] = '{"p12_rand",  4'd12, rs2,  '0, 0};
    vecs[4] = '{"p15_clamp", 4'd15, rs2,  '0, 0};
    vecs[5] = '{"p5_odd",    4'd5,  rs,   '0, 0};
    vecs[6] = '{"p1_last",   4'd1,  rs2,  '0, 0};
    for (int i = 0; i < 7; i++) begin
      vecs[i].exp_out   = model_perm(vecs[i].x_in, int'(vecs[i].rounds));
      vecs[i].exp_edges = exp_edges(int'(vecs[i].rounds));
    end

    // Reset state
    drive(1'b0, 4'd0, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_st("reset oX", dut_out(), '0);
    check_int("reset oBusy", bus.oBusy, 0);
    check_int("reset oDone", bus.oDone, 0);
    check_int("reset oValid", bus.oValid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single jobs
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Mid-run reset: a=12, abort after five rounds, no done may follow
    drive(1'b1, 4'd12, rs);
    @(negedge clk);
    drive(1'b0, 4'd12, rs);
    repeat (5) @(negedge clk);
    check_int("midrun busy_before_reset", bus.oBusy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_st("midrun reset oX", dut_out(), '0);
    check_int("midrun reset oBusy", bus.oBusy, 0);
    check_int("midrun reset oDone", bus.oDone, 0);
    check_int("midrun reset oValid", bus.oValid, 0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.oDone) n_done++;
    end
    check_int("midrun no_done_after_reset", n_done, 0);
    $display("[TB] job midrun_reset aborted, done pulses after reset=%0d", n_done);
    run_vec(vecs[6]);   // sequencer must still work after the abort

    // Start held high with fresh state every cycle
    L = exp_edges(12) - 1;
    n_done = 0; done1 = -1; done2 = -1; res1 = '0; res2 = '0;
    for (int k = 0; k <= 2 * L + 3; k++) begin
      xs[k] = rand_st();
      drive(1'b1, 4'd12, xs[k]);
      @(negedge clk);
      if (bus.oDone) begin
        n_done++;
        if (done1 < 0) begin done1 = k; res1 = dut_out(); end
        else begin done2 = k; res2 = dut_out(); end
      end
      if (k == L + 1) check_int("collision valid_before_reaccept", bus.oValid, 1);
      if (k == L + 2) check_int("collision valid_drops_on_reaccept", bus.oValid, 0);
    end
    drive(1'b0, 4'd0, '0);
    check_int("collision done_count", n_done, 2);
    check_int("collision first_done_edge", done1, L);
    check_int("collision second_done_edge", done2, 2 * L + 2);
    check_st("collision first_result", res1, model_perm(xs[0], 12));
    check_st("collision second_result", res2, model_perm(xs[L + 2], 12));
    $display("[TB] job collision dones=%0d at edges %0d,%0d", n_done, done1, done2);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so a stuck DUT can never hang the run.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
